// File: rtl/periferico_rx_fifo.sv
// Receiver for the per_send/per_ack four-phase handshake. Captured words go into a
// DEPTH-entry FIFO that the core drains through a first-word-fall-through valid/ready port.
module periferico_rx_fifo #(
  parameter int DATA_W      = 4,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FULL_MODE   = 0
) (
  input  logic                         per_clock,
  input  logic                         per_reset,
  input  logic                         per_send,
  output logic                         per_ack,
  input  logic [DATA_W-1:0]            in_per_dados,
  output logic [DATA_W-1:0]            out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic                         overflow,
  input  logic                         ovf_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);

  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } state_t;

  state_t                    state_q, state_d;
  logic [SYNC_STAGES-1:0]    sync_q;
  logic                      send_s;
  logic [AW-1:0]             wr_ptr, rd_ptr;
  logic [LW-1:0]             level_q;
  logic [DATA_W-1:0]         last_q;
  logic                      ovf_q;
  logic [DATA_W-1:0]         mem [DEPTH];
  logic                      full, empty, push, pop, drop;

  assign send_s = sync_q[SYNC_STAGES-1];
  assign full   = (level_q == LW'(DEPTH));
  assign empty  = (level_q == '0);
  assign pop    = !empty && out_ready;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d = state_q;
    push    = 1'b0;
    drop    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (send_s) begin
          if (!full) begin
            push    = 1'b1;
            state_d = ACK;
          end else if (FULL_MODE != 0) begin
            drop    = 1'b1;
            state_d = ACK;
          end
        end
      end
      ACK: begin
        if (!send_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge per_clock or negedge per_reset) begin
    if (!per_reset) begin
      state_q <= IDLE;
      sync_q  <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
      last_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= {sync_q[SYNC_STAGES-2:0], per_send};
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
        last_q <= mem[rd_ptr];
      end
      unique case ({push, pop})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
      // A drop on the same edge as a clear keeps the flag set.
      if (drop)         ovf_q <= 1'b1;
      else if (ovf_clr) ovf_q <= 1'b0;
    end
  end

  // NOTE: storage has no reset; out_data is masked by last_q while empty, so stale words never show.
  always_ff @(posedge per_clock) begin
    if (push) mem[wr_ptr] <= in_per_dados;
  end

  // While empty, show the last popped word (0 after reset) rather than whatever sits at rd_ptr.
  assign out_data  = empty ? last_q : mem[rd_ptr];
  assign out_valid = !empty;
  assign level     = level_q;
  assign per_ack   = (state_q == ACK);
  assign overflow  = (FULL_MODE != 0) ? ovf_q : 1'b0;

endmodule

// File: tb/tb_periferico_rx_fifo.sv
// Directed bench for periferico_rx_fifo: one backpressure instance and one drop-mode instance
// share all inputs; each scenario task checks the instance relevant to it.
module tb_periferico_rx_fifo;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       per_send;
  logic [3:0] dados;
  logic       out_ready;
  logic       ovf_clr;

  logic       ack0, valid0, ovf0;
  logic [3:0] data0;
  logic [2:0] level0;
  logic       ack1, valid1, ovf1;
  logic [3:0] data1;
  logic [2:0] level1;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  periferico_rx_fifo #(.DATA_W(4), .DEPTH(4), .SYNC_STAGES(2), .FULL_MODE(0)) dut0 (
    .per_clock(clk), .per_reset(rst_n), .per_send(per_send), .per_ack(ack0),
    .in_per_dados(dados), .out_data(data0), .out_valid(valid0), .out_ready(out_ready),
    .level(level0), .overflow(ovf0), .ovf_clr(ovf_clr)
  );

  periferico_rx_fifo #(.DATA_W(4), .DEPTH(4), .SYNC_STAGES(2), .FULL_MODE(1)) dut1 (
    .per_clock(clk), .per_reset(rst_n), .per_send(per_send), .per_ack(ack1),
    .in_per_dados(dados), .out_data(data1), .out_valid(valid1), .out_ready(out_ready),
    .level(level1), .overflow(ovf1), .ovf_clr(ovf_clr)
  );

  function automatic logic ack_of(input bit sel);
    return sel ? ack1 : ack0;
  endfunction

  function automatic logic [3:0] data_of(input bit sel);
    return sel ? data1 : data0;
  endfunction

  function automatic logic valid_of(input bit sel);
    return sel ? valid1 : valid0;
  endfunction

  // Bounded wait for per_ack to reach val; an expired budget counts as a mismatch.
  task automatic wait_ack(input bit sel, input logic val, input string name);
    int n = 0;
    while (ack_of(sel) !== val && n < 20) begin
      @(negedge clk);
      n++;
    end
    compared++;
    if (ack_of(sel) !== val) begin
      mismatched++;
      $display("FAIL %s: per_ack=%b, required %b within 20 cycles", name, ack_of(sel), val);
    end
  endtask

  task automatic send_word(input logic [3:0] w, input bit sel);
    dados    = w;
    per_send = 1'b1;
    @(negedge clk);
    wait_ack(sel, 1'b1, "ack_rise");
    per_send = 1'b0;
    @(negedge clk);
    wait_ack(sel, 1'b0, "ack_fall");
  endtask

  task automatic pop_check(input bit sel, input logic [3:0] exp, input string name);
    compared++;
    if (valid_of(sel) !== 1'b1 || data_of(sel) !== exp) begin
      mismatched++;
      $display("FAIL %s: valid=%b data=%h, required valid=1 data=%h", name, valid_of(sel), data_of(sel), exp);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic do_reset();
    per_reset_low();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic per_reset_low();
    rst_n     = 1'b0;
    per_send  = 1'b0;
    out_ready = 1'b0;
    ovf_clr   = 1'b0;
    dados     = 4'h0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    #2;
    rst_n    = 1'b0;
    per_send = 1'b1;
    dados    = 4'hA;
    #1;
    compared++;
    if (ack0 !== 1'b0 || level0 !== 3'd0 || valid0 !== 1'b0 || data0 !== 4'h0) begin
      mismatched++;
      $display("FAIL reset_async: ack=%b level=%0d valid=%b data=%h, required 0/0/0/0", ack0, level0, valid0, data0);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      compared++;
      if (ack0 !== 1'b0 || level0 !== 3'd0 || valid0 !== 1'b0 || data0 !== 4'h0) begin
        mismatched++;
        $display("FAIL reset_hold: ack=%b level=%0d valid=%b data=%h, required 0/0/0/0", ack0, level0, valid0, data0);
      end
    end
    rst_n = 1'b1;
    for (int e = 0; e < 2; e++) begin
      @(negedge clk);
      compared++;
      if (ack0 !== 1'b0 || valid0 !== 1'b0) begin
        mismatched++;
        $display("FAIL reset_early_edge%0d: ack=%b valid=%b, required 0/0", e, ack0, valid0);
      end
    end
    @(negedge clk);
    compared++;
    if (ack0 !== 1'b1 || data0 !== 4'hA || level0 !== 3'd1) begin
      mismatched++;
      $display("FAIL reset_capture_edge3: ack=%b data=%h level=%0d, required 1/a/1", ack0, data0, level0);
    end
    per_send = 1'b0;
    wait_ack(0, 1'b0, "reset_ack_fall");
  endtask

  task automatic test_single();
    do_reset();
    dados    = 4'hA;
    per_send = 1'b1;
    for (int e = 0; e < 2; e++) begin
      @(negedge clk);
      compared++;
      if (ack0 !== 1'b0) begin
        mismatched++;
        $display("FAIL single_pre_ack%0d: per_ack=%b, required 0", e, ack0);
      end
    end
    @(negedge clk);
    compared++;
    if (ack0 !== 1'b1 || data0 !== 4'hA || level0 !== 3'd1 || valid0 !== 1'b1) begin
      mismatched++;
      $display("FAIL single_capture: ack=%b data=%h level=%0d valid=%b, required 1/a/1/1", ack0, data0, level0, valid0);
    end
    dados = 4'hE;
    repeat (3) @(negedge clk);
    compared++;
    if (level0 !== 3'd1 || data0 !== 4'hA) begin
      mismatched++;
      $display("FAIL single_no_rewrite: level=%0d data=%h, required 1/a", level0, data0);
    end
    per_send = 1'b0;
    for (int e = 0; e < 2; e++) begin
      @(negedge clk);
      compared++;
      if (ack0 !== 1'b1) begin
        mismatched++;
        $display("FAIL single_ack_hold%0d: per_ack=%b, required 1", e, ack0);
      end
    end
    @(negedge clk);
    compared++;
    if (ack0 !== 1'b0 || level0 !== 3'd1) begin
      mismatched++;
      $display("FAIL single_ack_fall: ack=%b level=%0d, required 0/1", ack0, level0);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int i = 1; i <= 4; i++) send_word(4'(i), 0);
    compared++;
    if (level0 !== 3'd4 || data0 !== 4'h1) begin
      mismatched++;
      $display("FAIL bp_full: level=%0d data=%h, required 4/1", level0, data0);
    end
    dados    = 4'h5;
    per_send = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      compared++;
      if (ack0 !== 1'b0 || level0 !== 3'd4) begin
        mismatched++;
        $display("FAIL bp_blocked: ack=%b level=%0d, required 0/4", ack0, level0);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    compared++;
    if (level0 !== 3'd3 || data0 !== 4'h2 || ack0 !== 1'b0) begin
      mismatched++;
      $display("FAIL bp_pop_edge: level=%0d data=%h ack=%b, required 3/2/0", level0, data0, ack0);
    end
    @(negedge clk);
    compared++;
    if (level0 !== 3'd4 || ack0 !== 1'b1) begin
      mismatched++;
      $display("FAIL bp_release: level=%0d ack=%b, required 4/1", level0, ack0);
    end
    per_send = 1'b0;
    wait_ack(0, 1'b0, "bp_ack_fall");
    for (int i = 2; i <= 5; i++) pop_check(0, 4'(i), "bp_drain");
    compared++;
    if (valid0 !== 1'b0 || level0 !== 3'd0 || data0 !== 4'h5) begin
      mismatched++;
      $display("FAIL bp_empty_hold: valid=%b level=%0d data=%h, required 0/0/5", valid0, level0, data0);
    end
  endtask

  task automatic test_drop_mode();
    do_reset();
    for (int i = 1; i <= 5; i++) send_word(4'(i), 1);
    compared++;
    if (level1 !== 3'd4 || ovf1 !== 1'b1 || data1 !== 4'h1 || ovf0 !== 1'b0) begin
      mismatched++;
      $display("FAIL drop_overflow: level=%0d ovf=%b data=%h ovf_bp=%b, required 4/1/1/0", level1, ovf1, data1, ovf0);
    end
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    compared++;
    if (ovf1 !== 1'b0) begin
      mismatched++;
      $display("FAIL drop_clear: overflow=%b, required 0", ovf1);
    end
    dados    = 4'h6;
    per_send = 1'b1;
    repeat (2) @(negedge clk);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    compared++;
    if (ovf1 !== 1'b1 || ack1 !== 1'b1 || level1 !== 3'd4) begin
      mismatched++;
      $display("FAIL drop_set_wins: ovf=%b ack=%b level=%0d, required 1/1/4", ovf1, ack1, level1);
    end
    per_send = 1'b0;
    wait_ack(1, 1'b0, "drop_ack_fall");
    for (int i = 1; i <= 4; i++) pop_check(1, 4'(i), "drop_drain");
    compared++;
    if (valid1 !== 1'b0 || level1 !== 3'd0) begin
      mismatched++;
      $display("FAIL drop_empty: valid=%b level=%0d, required 0/0", valid1, level1);
    end
  endtask

  task automatic test_wrap();
    logic [3:0] w;
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      w        = 4'(i * 7 + 3);
      dados    = w;
      per_send = 1'b1;
      for (int n = 0; n < 20; n++) begin
        @(negedge clk);
        compared++;
        if (level0 > 3'd1) begin
          mismatched++;
          $display("FAIL wrap_level: level=%0d, required <=1", level0);
        end
        if (ack0 === 1'b1) break;
      end
      compared++;
      if (ack0 !== 1'b1 || data0 !== w || level0 !== 3'd1) begin
        mismatched++;
        $display("FAIL wrap_word%0d: ack=%b data=%h level=%0d, required 1/%h/1", i, ack0, data0, level0, w);
      end
      per_send = 1'b0;
      @(negedge clk);
      compared++;
      if (level0 !== 3'd0 || data0 !== w) begin
        mismatched++;
        $display("FAIL wrap_pop%0d: level=%0d data=%h, required 0/%h", i, level0, data0, w);
      end
      wait_ack(0, 1'b0, "wrap_ack_fall");
    end
    out_ready = 1'b0;
    send_word(4'hB, 0);
    dados    = 4'hC;
    per_send = 1'b1;
    repeat (2) @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    compared++;
    if (level0 !== 3'd1 || data0 !== 4'hC || ack0 !== 1'b1) begin
      mismatched++;
      $display("FAIL push_pop_same_edge: level=%0d data=%h ack=%b, required 1/c/1", level0, data0, ack0);
    end
    per_send = 1'b0;
    wait_ack(0, 1'b0, "push_pop_ack_fall");
    pop_check(0, 4'hC, "push_pop_drain");
  endtask

  task automatic test_mid_reset();
    do_reset();
    send_word(4'h7, 0);
    dados    = 4'h9;
    per_send = 1'b1;
    @(negedge clk);
    wait_ack(0, 1'b1, "mid_ack_rise");
    compared++;
    if (level0 !== 3'd2) begin
      mismatched++;
      $display("FAIL mid_level_before: level=%0d, required 2", level0);
    end
    #2;
    rst_n = 1'b0;
    #1;
    compared++;
    if (ack0 !== 1'b0 || level0 !== 3'd0 || valid0 !== 1'b0) begin
      mismatched++;
      $display("FAIL mid_reset_async: ack=%b level=%0d valid=%b, required 0/0/0", ack0, level0, valid0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    compared++;
    if (ack0 !== 1'b0) begin
      mismatched++;
      $display("FAIL mid_recapture_early: per_ack=%b, required 0", ack0);
    end
    @(negedge clk);
    compared++;
    if (ack0 !== 1'b1 || data0 !== 4'h9 || level0 !== 3'd1) begin
      mismatched++;
      $display("FAIL mid_recapture: ack=%b data=%h level=%0d, required 1/9/1", ack0, data0, level0);
    end
    per_send = 1'b0;
    wait_ack(0, 1'b0, "mid_ack_fall");
  endtask

  initial begin
    per_reset_low();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_single();
    test_backpressure();
    test_drop_mode();
    test_wrap();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded 200000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/periferico_rx_fifo.md
# periferico_rx_fifo

Parametrised receiver for the per_send/per_ack peripheral handshake. It synchronises the sender's per_send strobe, captures in_per_dados into a DEPTH-entry FIFO, and answers with a four-phase per_ack. The buffered words are drained by the core through a first-word-fall-through valid/ready port. A mode parameter selects the behaviour when the FIFO is full: hold off the sender (backpressure), or acknowledge and discard the word while setting a sticky overflow flag.

## Interface
- DATA_W, 4: width of in_per_dados and out_data.
- DEPTH, 4: FIFO entries; power of two, ≥2.
- SYNC_STAGES, 2: flops in the per_send synchroniser; ≥2.
- FULL_MODE, 0: 0 = backpressure (ack withheld while full); 1 = drop (ack given, word discarded, overflow set).
- per_clock  in  1  sole clock, rising edge.
- per_reset  in  1  asynchronous, active-low reset.
- per_send  in  1  sender request; asynchronous to per_clock.
- per_ack  out  1  four-phase acknowledge.
- in_per_dados  in  DATA_W  sender data; stable while per_send=1.
- out_data  out  DATA_W  FIFO head word; valid when out_valid=1.
- out_valid  out  1  FIFO not empty.
- out_ready  in  1  core pops the head on an edge where out_valid && out_ready.
- level  out  $clog2(DEPTH+1)  current occupancy, 0..DEPTH.
- overflow  out  1  sticky drop indicator; used only when FULL_MODE=1, otherwise tied to 0.
- ovf_clr  in  1  synchronous clear of overflow.

## Operation
- Reset (per_reset=0, takes effect immediately, no clock needed):
  - per_ack=0, out_valid=0, out_data=0, level=0, overflow=0.
  - Read/write pointers cleared; synchroniser flops cleared; FSM in IDLE.
- Synchroniser: per_send passes through SYNC_STAGES flops; the final stage output is send_s. in_per_dados is sampled directly, with no synchronisation; the protocol guarantees it is stable.
- FSM has two states:
  - IDLE: per_ack=0.
    - If send_s=1 and the FIFO is not full: write in_per_dados at wr_ptr, increment wr_ptr, go to ACK.
    - If send_s=1 and the FIFO is full, FULL_MODE=0: stay in IDLE, write nothing, keep per_ack=0. Retry on each edge until space is free.
    - If send_s=1 and the FIFO is full, FULL_MODE=1: write nothing, set overflow, go to ACK.
  - ACK: per_ack=1. When send_s=0, go to IDLE, which drops per_ack. No capture happens in ACK, so one request produces exactly one word.
- Full and not-full are evaluated on the level registered before the edge. A pop on the same edge does not free space for that edge's capture.
- Pop: on an edge where out_valid && out_ready, rd_ptr increments.
  - out_data is a combinational read of mem[rd_ptr].
  - When the FIFO is empty, out_data holds its last value. It is 0 after reset.
- Simultaneous push and pop: both take effect; level is unchanged.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. level tracks occupancy in a separate counter, or is derived from pointers one bit wider.
- Overflow flag: ovf_clr=1 clears overflow on the edge. If a drop occurs on the same edge, the set wins and overflow stays 1.
- Reset mid-handshake: per_ack drops at once and the FIFO is emptied. If per_send is still high after reset is released, it is treated as a new request and captured again.

## Timing
- Request to capture:
  - per_send first sampled high on edge E0 makes send_s=1 after edge E(SYNC_STAGES-1).
  - The capture and per_ack=1 occur on edge E(SYNC_STAGES).
  - The captured word appears on out_valid/out_data immediately after that same edge.
- Release to ack drop: per_send low sampled on edge F0 makes per_ack=0 after edge F(SYNC_STAGES).
- Back-to-back requests: minimum spacing is 2·(SYNC_STAGES+1) cycles per word, set by the four-phase round trip.
- Pop latency: level and out_data update on the popping edge. With DEPTH=1 occupancy, out_valid falls on that edge.
- Backpressure release (FULL_MODE=0): the first pop makes the FIFO not full on edge P. The pending capture and per_ack=1 follow on edge P+1.

## Test plan
All scenarios use DATA_W=4, DEPTH=4, SYNC_STAGES=2 unless stated.

- Reset: hold per_reset=0 with per_send=1 -> per_ack=0, level=0, out_valid=0, out_data=0 throughout; after release, 0xA is captured on the 3rd edge.
- Single handshake: per_send=1 with data 0xA -> per_ack rises 2 edges after per_send is first sampled; out_data=0xA, level=1. Change data to 0xE mid-ACK -> no second write. Drop per_send -> per_ack falls 2 edges later.
- Fill with backpressure (FULL_MODE=0): send 0x1, 0x2, 0x3, 0x4 then 0x5 with out_ready=0 -> level=4 and per_ack stays 0 for the 5th request. Pulse out_ready for one cycle -> 0x1 is popped, then 0x5 is captured one edge later and per_ack rises. Subsequent drain order is 0x2, 0x3, 0x4, 0x5.
- Drop mode (FULL_MODE=1): same 5 words -> per_ack is given for the 5th, level stays 4, overflow=1, and the drain yields 0x1 to 0x4. ovf_clr for one cycle -> overflow=0.
- Wrap and simultaneous push/pop: stream 10 words with out_ready=1 held -> data order is preserved across pointer wrap, level never exceeds 1, and level is unchanged on push+pop edges.
- Mid-handshake reset: assert per_reset=0 while in ACK with level=2 -> per_ack=0 and level=0 immediately, without waiting for a clock edge.
